// File: rtl/ps2_key_ctrl_if.sv
// PS/2 keyboard port bundle: raw keyboard lines toward the controller, decoded key state back.
// The controller uses the slave view; the keyboard side (or a bench) uses the master view.
interface ps2_key_ctrl_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keys;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  keys, key_press, key_release, code, code_valid, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keys, key_press, key_release, code, code_valid, frame_err
    );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 receive controller: synchronise and filter the raw lines, frame 11-bit packets, decode make/break/E0.
// Optional macro PS2_ARROW_KEYS_EN aliases E0-prefixed arrow codes onto keys[3:1].
module ps2_key_ctrl #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 100000,
    parameter logic [7:0]  KEY0_CODE   = 8'h29,
    parameter logic [7:0]  KEY1_CODE   = 8'h1D,
    parameter logic [7:0]  KEY2_CODE   = 8'h23,
    parameter logic [7:0]  KEY3_CODE   = 8'h1C
) (
    input  logic          clk,
    input  logic          rst,
    ps2_key_ctrl_if.slave bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0][7:0] KEY_CODES = {KEY3_CODE, KEY2_CODE, KEY1_CODE, KEY0_CODE};

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]            r_clk_sync;
    logic [1:0]            r_data_sync;
    logic [FILTER_LEN-1:0] r_clk_sh;
    logic [FILTER_LEN-1:0] r_data_sh;
    logic                  r_clk_f;
    logic                  r_clk_f_q;
    logic                  r_data_f;
    logic                  w_fall;

    // NOTE: non-blocking assignments make every register here see the pre-edge value of the others,
    // so the synchronizer and filter stages shift correctly regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_sh    <= '1;
            r_data_sh   <= '1;
            r_clk_f     <= 1'b1;
            r_clk_f_q   <= 1'b1;
            r_data_f    <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], bus.ps2_clk};
            r_data_sync <= {r_data_sync[0], bus.ps2_data};
            r_clk_sh    <= {r_clk_sh[FILTER_LEN-2:0], r_clk_sync[1]};
            r_data_sh   <= {r_data_sh[FILTER_LEN-2:0], r_data_sync[1]};
            if (&r_clk_sh)
                r_clk_f <= 1'b1;
            else if (~|r_clk_sh)
                r_clk_f <= 1'b0;
            if (&r_data_sh)
                r_data_f <= 1'b1;
            else if (~|r_data_sh)
                r_data_f <= 1'b0;
            r_clk_f_q <= r_clk_f;
        end
    end

    assign w_fall = r_clk_f_q & ~r_clk_f;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]     r_code;
    logic           r_code_valid;
    logic           r_frame_err;
    logic           w_timeout;
    logic           w_frame_ok;
    logic           w_load_code;
    logic           w_err;

    assign w_timeout  = (r_state != S_IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYC));
    assign w_frame_ok = r_data_f & (^{r_shift, r_parity});

    // NOTE: every output of this block gets a default first, so no path can leave one unassigned
    // and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load_code = 1'b0;
        w_err       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_err       = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!r_data_f) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (w_frame_ok)
                        w_load_code = 1'b1;
                    else
                        w_err = 1'b1;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_code_valid <= w_load_code;
            r_frame_err  <= w_err;
            if (w_load_code)
                r_code <= r_shift;
            // The watchdog only runs inside a frame and restarts on every clock fall.
            if (r_state == S_IDLE || w_timeout || w_fall)
                r_to_cnt <= '0;
            else
                r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_fall && !w_timeout) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {r_data_f, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    S_PARITY: r_parity <= r_data_f;
                    default:  ;
                endcase
            end
        end
    end

    logic [3:0] r_keys;
    logic [3:0] r_key_press;
    logic [3:0] r_key_release;
    logic       r_ext;
    logic       r_brk;
    logic [3:0] w_keys_nxt;
    logic       w_ext_nxt;
    logic       w_brk_nxt;

    always_comb begin
        w_keys_nxt = r_keys;
        w_ext_nxt  = r_ext;
        w_brk_nxt  = r_brk;
        if (r_code_valid) begin
            if (r_code == 8'hE0) begin
                w_ext_nxt = 1'b1;
            end else if (r_code == 8'hF0) begin
                w_brk_nxt = 1'b1;
            end else begin
                if (r_ext) begin
`ifdef PS2_ARROW_KEYS_EN
                    case (r_code)
                        8'h75:   w_keys_nxt[1] = ~r_brk;
                        8'h74:   w_keys_nxt[2] = ~r_brk;
                        8'h6B:   w_keys_nxt[3] = ~r_brk;
                        default: ;
                    endcase
`endif
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (r_code == KEY_CODES[i])
                            w_keys_nxt[i] = ~r_brk;
                    end
                end
                w_ext_nxt = 1'b0;
                w_brk_nxt = 1'b0;
            end
        end
    end

    // Edge pulses are derived from the next key state so they line up with the keys update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_keys        <= '0;
            r_key_press   <= '0;
            r_key_release <= '0;
            r_ext         <= 1'b0;
            r_brk         <= 1'b0;
        end else begin
            r_keys        <= w_keys_nxt;
            r_key_press   <= w_keys_nxt & ~r_keys;
            r_key_release <= ~w_keys_nxt & r_keys;
            r_ext         <= w_ext_nxt;
            r_brk         <= w_brk_nxt;
        end
    end

    assign bus.keys        = r_keys;
    assign bus.key_press   = r_key_press;
    assign bus.key_release = r_key_release;
    assign bus.code        = r_code;
    assign bus.code_valid  = r_code_valid;
    assign bus.frame_err   = r_frame_err;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: framed-byte vector table plus hand sequences for
// latency, timeout, typematic, E0 prefix and mid-frame reset; a scoreboard checks every byte/error event.
module tb_ps2_key_ctrl;

    localparam int HALF   = 16;
    localparam int TO_CYC = 1000;
`ifdef PS2_ARROW_KEYS_EN
    localparam bit ARROW = 1'b1;
`else
    localparam bit ARROW = 1'b0;
`endif

    logic clk;
    logic rst;

    ps2_key_ctrl_if bus ();

    ps2_key_ctrl #(
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         bad_stop;
        logic [3:0] exp_keys;
        logic [7:0] exp_code;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   press_cnt[4];
    int   rel_cnt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard consumer and pulse counters.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.code_valid || bus.frame_err) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: code_valid=%0b frame_err=%0b code=%0h, expected no event",
                             bus.code_valid, bus.frame_err, bus.code);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("event_kind", {30'd0, bus.code_valid, bus.frame_err}, {30'd0, ~e.is_err, e.is_err});
                    if (!e.is_err)
                        check("event_code", {24'd0, bus.code}, {24'd0, e.code});
                end
            end
            for (int i = 0; i < 4; i++) begin
                press_cnt[i] += int'(bus.key_press[i]);
                rel_cnt[i]   += int'(bus.key_release[i]);
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0,
                              input int nbits = 11, input bit push = 1'b1);
        logic [10:0] bits;
        exp_t        e;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        if (push) begin
            e.is_err = bad_par | bad_stop;
            e.code   = b;
            sb_q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        @(negedge clk);
        bus.ps2_data = 1'b1;
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[11];
    bit   cv_seen;
    int   p_base;
    int   r_base;

    initial begin
        vecs[0]  = '{8'hF0, 1'b0, 1'b0, 4'b1000, 8'hF0};
        vecs[1]  = '{8'h1C, 1'b0, 1'b0, 4'b0000, 8'h1C};
        vecs[2]  = '{8'h1D, 1'b1, 1'b0, 4'b0000, 8'h1C};
        vecs[3]  = '{8'h1D, 1'b0, 1'b0, 4'b0010, 8'h1D};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 4'b0010, 8'hF0};
        vecs[5]  = '{8'h1D, 1'b0, 1'b0, 4'b0000, 8'h1D};
        vecs[6]  = '{8'h23, 1'b0, 1'b1, 4'b0000, 8'h1D};
        vecs[7]  = '{8'h23, 1'b0, 1'b0, 4'b0100, 8'h23};
        vecs[8]  = '{8'h55, 1'b0, 1'b0, 4'b0100, 8'h55};
        vecs[9]  = '{8'hF0, 1'b0, 1'b0, 4'b0100, 8'hF0};
        vecs[10] = '{8'h23, 1'b0, 1'b0, 4'b0000, 8'h23};
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
        end

        rst          = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_keys", {28'd0, bus.keys}, 32'd0);
        check("rst_pulses", {24'd0, bus.key_press, bus.key_release}, 32'd0);
        check("rst_code", {24'd0, bus.code}, 32'd0);
        check("rst_flags", {30'd0, bus.code_valid, bus.frame_err}, 32'd0);
        rst = 1'b0;
        settle();

        // First make code: keys and key_press one cycle after code_valid, each pulse one cycle wide.
        fork
            send_frame(8'h1C);
            begin
                cv_seen = 1'b0;
                for (int i = 0; i < 1000 && !cv_seen; i++) begin
                    @(negedge clk);
                    if (bus.code_valid) cv_seen = 1'b1;
                end
                check("cv_seen", {31'd0, cv_seen}, 32'd1);
                @(negedge clk);
                check("a_keys", {28'd0, bus.keys}, 32'b1000);
                check("a_press", {28'd0, bus.key_press}, 32'b1000);
                check("a_cv_width", {31'd0, bus.code_valid}, 32'd0);
                @(negedge clk);
                check("a_press_width", {28'd0, bus.key_press}, 32'd0);
            end
        join
        settle();

        for (int v = 0; v < 11; v++) begin
            send_frame(vecs[v].b, vecs[v].bad_par, vecs[v].bad_stop);
            settle();
            check($sformatf("vec%0d_keys", v), {28'd0, bus.keys}, {28'd0, vecs[v].exp_keys});
            check($sformatf("vec%0d_code", v), {24'd0, bus.code}, {24'd0, vecs[v].exp_code});
        end
        check("press_cnt0", press_cnt[0], 0);
        check("press_cnt1", press_cnt[1], 1);
        check("press_cnt2", press_cnt[2], 1);
        check("press_cnt3", press_cnt[3], 1);
        check("rel_cnt1", rel_cnt[1], 1);
        check("rel_cnt2", rel_cnt[2], 1);
        check("rel_cnt3", rel_cnt[3], 1);

        // Start plus four data bits, then silence: exactly one timeout error, then recovery.
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.code   = 8'h00;
            sb_q.push_back(e);
        end
        send_frame(8'h29, 1'b0, 1'b0, 5, 1'b0);
        repeat (TO_CYC + 10) @(negedge clk);
        check("timeout_consumed", sb_q.size(), 0);
        check("timeout_code", {24'd0, bus.code}, 32'h23);
        send_frame(8'h29);
        settle();
        check("after_to_keys", {28'd0, bus.keys}, 32'b0001);

        // Typematic repeats of a held key.
        send_frame(8'h29);
        settle();
        send_frame(8'h29);
        settle();
        check("typematic_keys", {28'd0, bus.keys}, 32'b0001);
        check("typematic_press", press_cnt[0], 1);

        // Extended (E0) make and break of the up arrow.
        p_base = press_cnt[1];
        r_base = rel_cnt[1];
        send_frame(8'hE0);
        send_frame(8'h75);
        settle();
        check("e0_make_keys", {28'd0, bus.keys}, {28'd0, 1'b0, 1'b0, ARROW, 1'b1});
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h75);
        settle();
        check("e0_break_keys", {28'd0, bus.keys}, 32'b0001);
        check("e0_press", press_cnt[1] - p_base, {31'd0, ARROW});
        check("e0_release", rel_cnt[1] - r_base, {31'd0, ARROW});

        // Reset in the middle of an E0 sequence with a partial frame in flight.
        send_frame(8'hE0);
        send_frame(8'h75);
        send_frame(8'hE0);
        settle();
        send_frame(8'h6B, 1'b0, 1'b0, 4, 1'b0);
        check("pre_rst_keys", {28'd0, bus.keys}, {28'd0, 1'b0, 1'b0, ARROW, 1'b1});
        rst = 1'b1;
        #1;
        check("mid_rst_keys", {28'd0, bus.keys}, 32'd0);
        check("mid_rst_code", {24'd0, bus.code}, 32'd0);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        settle();
        send_frame(8'h1C);
        settle();
        check("post_rst_keys", {28'd0, bus.keys}, 32'b1000);
        check("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
